vcb_mod_updown: RTL and testbench
=================================

// Module: vcb_mod_updown
// PURPOSE
//  Parametrised successor to the 4-bit CE/set counter: a WIDTH-bit modulo-MODULUS up/down
//  counter with sync set, sync clear, parallel load, and wrap or saturate mode.
//  TC/CEO cascade outputs chain instances into multi-digit counters (decade, timers).
//  Used in the lab display/timing paths; single clock domain.
// PARAMETERS
//  WIDTH     4   counter width in bits (>=1)
//  MODULUS   16  count range 0..MODULUS-1; legal 2..2**WIDTH
//  SATURATE  0   0 = wrap at terminal count; 1 = hold at terminal count
// PORTS
//  clk    in   1      clock, rising edge active
//  rst_n  in   1      asynchronous reset, active-low
//  ce     in   1      clock enable for count and load
//  s      in   1      synchronous set to MODULUS-1 (ignores ce)
//  r      in   1      synchronous clear to 0, also clears ovf (ignores ce)
//  l      in   1      synchronous parallel load of di (needs ce)
//  di     in   WIDTH  load data
//  up     in   1      direction: 1 = up, 0 = down
//  Q      out  WIDTH  count value, registered
//  TC     out  1      terminal count, combinational from Q and up
//  CEO    out  1      cascade enable = ce & TC
//  ovf    out  1      sticky overflow/underflow flag, registered
// BEHAVIOUR
//  - One clock, clk; rst_n is asynchronous, active-low.
//    While rst_n=0: Q=0, ovf=0 immediately, with no clock edge needed.
//  - Reset release is synchronous-safe: the first active edge is the first clk rise
//    with rst_n=1.
//  - Priority at each rising edge, highest first:
//    1. r     -> Q<=0, ovf<=0
//    2. s     -> Q<=MODULUS-1 (ovf unchanged)
//    3. ce&l  -> Q<=min(di, MODULUS-1); out-of-range di clamps, no ovf
//    4. ce    -> count, see below
//    5. else  -> hold
//  - Count, up=1:
//    Q<MODULUS-1 -> Q+1.
//    Q==MODULUS-1 -> Q<=0 and ovf<=1 (wrap), or hold and ovf<=1 (SATURATE).
//  - Count, up=0:
//    Q>0 -> Q-1.
//    Q==0 -> Q<=MODULUS-1 and ovf<=1 (wrap), or hold and ovf<=1 (SATURATE).
//  - TC = up ? (Q==MODULUS-1) : (Q==0). Purely combinational, so a change of up
//    re-evaluates TC in the same cycle.
//  - After reset: TC=0 if up=1, TC=1 if up=0. CEO=0 whenever ce=0.
//  - Q never exceeds MODULUS-1 under any input sequence.
//  - Arithmetic is done in WIDTH+1 bits, so MODULUS=2**WIDTH wraps without truncation
//    issues.
//  - ovf is sticky: it is cleared only by r or rst_n.
//  - Direction change takes effect at the next counting edge; there is no pipeline.
//    Count latency is 1 clk.
//  - rst_n asserted mid-count overrides everything asynchronously.
//    s, r and l asserted in the same cycle resolve by the priority list above.
//  - Illegal MODULUS (<2 or >2**WIDTH) is reported by an elaboration-time check.
// TESTING
//  Use WIDTH=4, MODULUS=10 unless stated otherwise. Tclk=20 ns.
//  1. Async reset: count to Q=5, drop rst_n mid-period
//     -> Q=0 and ovf=0 before the next clk edge; Q stays 0 while rst_n=0.
//  2. Up wrap: ce=1, up=1 from 0 -> Q=9 after 9 edges with TC=1, CEO=1;
//     10th edge -> Q=0, ovf=1.
//     Then ce=0 -> Q holds, CEO=0, TC unchanged.
//  3. Down/saturate: up=0 from Q=0, SATURATE=0 -> Q=9, ovf=1.
//     With SATURATE=1 -> Q stays 0, TC=1, ovf=1.
//  4. Controls: s=1 with ce=0 -> Q=9 next edge. r=1 with s=1 -> Q=0, ovf=0.
//     l=1, ce=1, di=12 -> Q=9. l=1 with ce=0 -> Q holds.
//  5. Cascade: low.CEO -> high.ce, both MODULUS=10, 100 ce-cycles
//     -> {high,low} runs 00..99; low.CEO pulses on every xx9; high.CEO is high only
//     at 99; next state 00.
//  6. Boundary: WIDTH=4, MODULUS=16, up=1 from 15 -> Q=0, ovf=1.
//     Switch up=0 at Q=0 -> TC=1 in the same cycle.

Source files
------------

// File: rtl/vcb_mod_updown_if.sv
// -----------------------------------------------------------------------------
// vcb_mod_updown_if
// Bundles the control inputs and the count/cascade outputs of vcb_mod_updown.
//   master : drives ce, s, r, l, di, up; observes Q, TC, CEO, ovf
//   slave  : the counter itself (inverse directions)
// Parameter WIDTH must match the WIDTH of the counter it is attached to.
// -----------------------------------------------------------------------------
interface vcb_mod_updown_if #(
    parameter int WIDTH = 4
);
    logic             ce;   // clock enable for count and load
    logic             s;    // synchronous set to MODULUS-1
    logic             r;    // synchronous clear (also clears ovf)
    logic             l;    // synchronous parallel load (qualified by ce)
    logic [WIDTH-1:0] di;   // load data
    logic             up;   // 1 = count up, 0 = count down
    logic [WIDTH-1:0] Q;    // registered count value
    logic             TC;   // terminal count for the current direction
    logic             CEO;  // cascade enable out
    logic             ovf;  // sticky overflow/underflow flag

    modport master (
        output ce, s, r, l, di, up,
        input  Q, TC, CEO, ovf
    );

    modport slave (
        input  ce, s, r, l, di, up,
        output Q, TC, CEO, ovf
    );
endinterface

// File: rtl/vcb_mod_updown.sv
// -----------------------------------------------------------------------------
// vcb_mod_updown
// WIDTH-bit modulo-MODULUS up/down counter with synchronous set, clear and
// parallel load, wrap or saturate at the terminal count, a sticky
// overflow/underflow flag and TC/CEO outputs for cascading digits.
// Ports:
//   clk    : clock, rising edge active
//   rst_n  : asynchronous reset, active-low (Q=0, ovf=0)
//   bus    : vcb_mod_updown_if.slave
//            in  ce, s, r, l, di[WIDTH], up
//            out Q[WIDTH], TC, CEO, ovf
// Priority per edge: r > s > ce&l > ce (count) > hold.
// -----------------------------------------------------------------------------
module vcb_mod_updown #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    vcb_mod_updown_if.slave bus
);

    // Upper bound written as a shift so wide WIDTH values cannot overflow
    // the elaboration-time arithmetic: MODULUS > 2**WIDTH <=> (MODULUS-1)>>WIDTH != 0.
    generate
        if (MODULUS < 2 || ((MODULUS - 1) >> WIDTH) != 0) begin : g_bad_modulus
            $error("vcb_mod_updown: MODULUS=%0d illegal for WIDTH=%0d (legal 2..2**WIDTH)",
                   MODULUS, WIDTH);
        end
    endgenerate

    // Terminal value held one bit wider than Q so MODULUS=2**WIDTH never truncates.
    localparam logic [WIDTH:0]   TERM_X = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TERM   = TERM_X[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             at_top, at_zero;

    assign at_top  = ({1'b0, q_q} == TERM_X);
    assign at_zero = (q_q == '0);

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (bus.r) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (bus.s) begin
            q_d = TERM;
        end else if (bus.ce && bus.l) begin
            // Out-of-range load data clamps to the top of the range without flagging.
            q_d = (bus.di > TERM) ? TERM : bus.di;
        end else if (bus.ce) begin
            if (bus.up) begin
                if (at_top) begin
                    ovf_d = 1'b1;
                    q_d   = SATURATE ? q_q : '0;
                end else begin
                    // Cannot carry out: at_top has already been excluded.
                    q_d = q_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    ovf_d = 1'b1;
                    q_d   = SATURATE ? q_q : TERM;
                end else begin
                    q_d = q_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    // TC follows up combinationally so a direction change is seen in the same cycle.
    assign bus.Q   = q_q;
    assign bus.ovf = ovf_q;
    assign bus.TC  = bus.up ? at_top : at_zero;
    assign bus.CEO = bus.ce & bus.TC;

endmodule

// File: tb/tb_vcb_mod_updown.sv
// -----------------------------------------------------------------------------
// tb_vcb_mod_updown
// Directed bench for vcb_mod_updown: a vector table on a MODULUS=10 wrap
// counter plus hand-written sequences for async reset, saturate mode, a
// two-digit decade cascade and the MODULUS=2**WIDTH boundary.
// -----------------------------------------------------------------------------
module tb_vcb_mod_updown;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    vcb_mod_updown_if #(.WIDTH(4)) if0  ();
    vcb_mod_updown_if #(.WIDTH(4)) if1  ();
    vcb_mod_updown_if #(.WIDTH(4)) iflo ();
    vcb_mod_updown_if #(.WIDTH(4)) ifhi ();
    vcb_mod_updown_if #(.WIDTH(4)) if16 ();

    vcb_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u0   (.clk(clk), .rst_n(rst_n), .bus(if0));
    vcb_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u1   (.clk(clk), .rst_n(rst_n), .bus(if1));
    vcb_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_lo (.clk(clk), .rst_n(rst_n), .bus(iflo));
    vcb_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_hi (.clk(clk), .rst_n(rst_n), .bus(ifhi));
    vcb_mod_updown #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u16  (.clk(clk), .rst_n(rst_n), .bus(if16));

    // Decade cascade: the high digit advances only when the low digit hands over.
    assign ifhi.ce = iflo.CEO;

    typedef struct {
        logic       r, s, l, ce, up;
        logic [3:0] di;
        logic [3:0] q;
        logic       ovf, tc, ceo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, s, l, ce, up, input logic [3:0] di,
                                input logic [3:0] q, input logic ovf, tc, ceo);
        vec_t v;
        v.r = r; v.s = s; v.l = l; v.ce = ce; v.up = up; v.di = di;
        v.q = q; v.ovf = ovf; v.tc = tc; v.ceo = ceo;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One active edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {if0.ce, if0.s, if0.r, if0.l, if0.up, if0.di} = '0;
        {if1.ce, if1.s, if1.r, if1.l, if1.up, if1.di} = '0;
        {iflo.ce, iflo.s, iflo.r, iflo.l, iflo.up, iflo.di} = '0;
        {ifhi.s, ifhi.r, ifhi.l, ifhi.up, ifhi.di} = '0;
        {if16.ce, if16.s, if16.r, if16.l, if16.up, if16.di} = '0;
        if0.up = 1'b1;

        // ---------------- reset state ----------------
        #1;
        chk("rst_q",      32'(if0.Q),   32'd0);
        chk("rst_ovf",    32'(if0.ovf), 32'd0);
        chk("rst_tc_up",  32'(if0.TC),  32'd0);
        chk("rst_ceo",    32'(if0.CEO), 32'd0);
        if0.up = 1'b0;
        #1;
        chk("rst_tc_down", 32'(if0.TC), 32'd1);
        if0.up = 1'b1;
        #13 rst_n = 1'b1;                       // released mid-period, t=15

        // ---------------- async reset mid-count ----------------
        if0.ce = 1'b1;
        repeat (5) step();
        chk("cnt_to_5", 32'(if0.Q), 32'd5);
        #5 rst_n = 1'b0;                        // no clock edge in between
        #1;
        chk("async_q",   32'(if0.Q),   32'd0);
        chk("async_ovf", 32'(if0.ovf), 32'd0);
        step();
        chk("async_hold_q", 32'(if0.Q), 32'd0);
        if0.ce = 1'b0;
        #3 rst_n = 1'b1;

        // ---------------- vector table on u0 (MODULUS=10, wrap) ----------------
        //    r s l ce up di   q  ovf tc ceo
        for (int k = 1; k <= 9; k++)
            add(0, 0, 0, 1, 1, 4'd0, 4'(k), 0, (k == 9), (k == 9));
        add(0, 0, 0, 1, 1, 4'd0,  4'd0, 1, 0, 0);   // up wrap sets ovf
        add(0, 0, 0, 0, 1, 4'd0,  4'd0, 1, 0, 0);   // ce=0 holds, CEO=0
        add(0, 0, 0, 0, 1, 4'd0,  4'd0, 1, 0, 0);   // ovf sticky
        add(1, 0, 0, 0, 1, 4'd0,  4'd0, 0, 0, 0);   // r clears ovf
        add(0, 0, 0, 1, 0, 4'd0,  4'd9, 1, 0, 0);   // down wrap 0->9
        add(0, 0, 0, 1, 0, 4'd0,  4'd8, 1, 0, 0);
        add(1, 0, 0, 0, 1, 4'd0,  4'd0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 4'd0,  4'd9, 0, 1, 0);   // s ignores ce
        add(1, 1, 0, 0, 1, 4'd0,  4'd0, 0, 0, 0);   // r beats s
        add(0, 0, 1, 1, 1, 4'd12, 4'd9, 0, 1, 1);   // clamp, no ovf
        add(0, 0, 1, 0, 1, 4'd3,  4'd9, 0, 1, 0);   // load needs ce
        add(0, 0, 1, 1, 1, 4'd4,  4'd4, 0, 0, 0);   // in-range load
        add(0, 0, 1, 1, 0, 4'd7,  4'd7, 0, 0, 0);   // load beats count
        add(0, 0, 0, 1, 0, 4'd0,  4'd6, 0, 0, 0);   // count down
        add(0, 1, 1, 1, 1, 4'd2,  4'd9, 0, 1, 1);   // s beats load
        add(1, 1, 1, 1, 1, 4'd2,  4'd0, 0, 0, 0);   // r beats all
        add(0, 0, 1, 1, 0, 4'd9,  4'd9, 0, 0, 0);   // load exact top
        add(0, 0, 0, 0, 0, 4'd0,  4'd9, 0, 0, 0);   // hold

        foreach (vecs[i]) begin
            if0.r = vecs[i].r; if0.s = vecs[i].s; if0.l = vecs[i].l;
            if0.ce = vecs[i].ce; if0.up = vecs[i].up; if0.di = vecs[i].di;
            step();
            chk($sformatf("vec%0d_q",   i), 32'(if0.Q),   32'(vecs[i].q));
            chk($sformatf("vec%0d_ovf", i), 32'(if0.ovf), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_tc",  i), 32'(if0.TC),  32'(vecs[i].tc));
            chk($sformatf("vec%0d_ceo", i), 32'(if0.CEO), 32'(vecs[i].ceo));
        end
        {if0.ce, if0.s, if0.r, if0.l} = '0;

        // ---------------- saturate mode (u1) ----------------
        if1.up = 1'b0; if1.ce = 1'b1;
        step();
        chk("sat_dn_q",   32'(if1.Q),   32'd0);
        chk("sat_dn_tc",  32'(if1.TC),  32'd1);
        chk("sat_dn_ovf", 32'(if1.ovf), 32'd1);
        step();
        chk("sat_dn_hold", 32'(if1.Q), 32'd0);
        if1.s = 1'b1;
        step();
        chk("sat_set_q",   32'(if1.Q),   32'd9);
        chk("sat_set_ovf", 32'(if1.ovf), 32'd1);
        if1.s = 1'b0; if1.up = 1'b1;
        step();
        chk("sat_up_hold", 32'(if1.Q),  32'd9);
        chk("sat_up_tc",   32'(if1.TC), 32'd1);
        if1.r = 1'b1; if1.ce = 1'b0;
        step();
        chk("sat_clr", 32'({if1.Q, if1.ovf}), 32'd0);
        if1.r = 1'b0;

        // ---------------- decade cascade 00..99 -> 00 ----------------
        iflo.up = 1'b1; ifhi.up = 1'b1; iflo.ce = 1'b1;
        #1;
        for (int n = 0; n <= 100; n++) begin
            logic [9:0] exp_v;
            exp_v = {4'((n % 100) / 10), 4'(n % 10), (n % 10 == 9), (n % 100 == 99)};
            chk($sformatf("casc%0d", n), 32'({ifhi.Q, iflo.Q, iflo.CEO, ifhi.CEO}), 32'(exp_v));
            if (n < 100) step();
        end
        iflo.ce = 1'b0;

        // ---------------- MODULUS = 2**WIDTH boundary (u16) ----------------
        if16.s = 1'b1;
        step();
        chk("m16_set", 32'(if16.Q), 32'd15);
        if16.s = 1'b0; if16.ce = 1'b1; if16.up = 1'b1;
        #1;
        chk("m16_tc_top", 32'(if16.TC), 32'd1);
        step();
        chk("m16_wrap_q",   32'(if16.Q),   32'd0);
        chk("m16_wrap_ovf", 32'(if16.ovf), 32'd1);
        chk("m16_tc_up0",   32'(if16.TC),  32'd0);
        if16.ce = 1'b0; if16.up = 1'b0;
        #1;
        chk("m16_tc_dn0",  32'(if16.TC),  32'd1);
        chk("m16_ceo_off", 32'(if16.CEO), 32'd0);
        if16.ce = 1'b1;
        #1;
        chk("m16_ceo_on", 32'(if16.CEO), 32'd1);
        if16.ce = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
